// File: rtl/min_cost_select.sv
// min_cost_select
// Winner-take-all disparity selector. Consumes one candidate cost per cycle
// (index 0..num_disp-1 for one pixel), keeps the strictly-lowest cost (ties
// keep the lower index) and emits one registered result per pixel.
// Candidate-order violations are reported on seq_err.
//
// Optional feature: define UNIQUENESS_CHECK_EN to track the second-best cost
// and flag ambiguous matches on disp_invalid (gap to the winner < uniq_margin).
// Without it disp_invalid is tied low.
//
// Ports:
//   clk, reset    clock, synchronous active-high reset
//   sum           candidate cost
//   in_coords     pixel coordinates {y, x}, taken from the index-0 candidate
//   blk_index_i   candidate index
//   sum_valid     candidate qualifier (no backpressure)
//   disp          winning index
//   disp_cost     winning cost
//   out_coords    coordinates of the completed pixel
//   disp_invalid  ambiguous-match flag
//   disp_valid    one-cycle result strobe
//   seq_err       one-cycle sequence-violation strobe
module min_cost_select #(
  parameter int num_disp    = 64,
  parameter int cost_bits   = 8,
  parameter int disp_bits   = (num_disp > 1) ? $clog2(num_disp) : 1,
  parameter int uniq_margin = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [cost_bits-1:0] sum,
  input  logic [15:0]          in_coords,
  input  logic [15:0]          blk_index_i,
  input  logic                 sum_valid,
  output logic [disp_bits-1:0] disp,
  output logic [cost_bits-1:0] disp_cost,
  output logic [15:0]          out_coords,
  output logic                 disp_invalid,
  output logic                 disp_valid,
  output logic                 seq_err
);

  localparam logic [15:0] LAST_IDX = 16'(num_disp - 1);

  typedef enum logic {IDLE, ACCUM} state_t;

  state_t               state;
  logic [15:0]          exp_idx;
  logic [cost_bits-1:0] best_cost;
  logic [disp_bits-1:0] best_idx;
  logic [15:0]          pix_coords;

  // Comparison against the running best is combinational so the last
  // candidate can win and land in the result register in the same cycle.
  logic                 take;
  logic [cost_bits-1:0] nxt_best_cost;
  logic [disp_bits-1:0] nxt_best_idx;
  logic                 ambiguous;

  always_comb begin
    take          = (sum < best_cost);
    nxt_best_cost = take ? sum : best_cost;
    nxt_best_idx  = take ? blk_index_i[disp_bits-1:0] : best_idx;
  end

`ifdef UNIQUENESS_CHECK_EN
  logic [cost_bits-1:0] second_cost;
  logic [cost_bits-1:0] nxt_second;
  logic [cost_bits-1:0] gap;

  // A displaced best becomes the runner-up; otherwise the candidate competes
  // for second place. second >= best always, so the subtraction never wraps.
  always_comb begin
    nxt_second = take ? best_cost : ((sum < second_cost) ? sum : second_cost);
    gap        = nxt_second - nxt_best_cost;
    ambiguous  = (int'(gap) < uniq_margin);
  end
`else
  always_comb ambiguous = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      exp_idx      <= '0;
      best_cost    <= '0;
      best_idx     <= '0;
      pix_coords   <= '0;
      disp         <= '0;
      disp_cost    <= '0;
      out_coords   <= '0;
      disp_invalid <= 1'b0;
      disp_valid   <= 1'b0;
      seq_err      <= 1'b0;
`ifdef UNIQUENESS_CHECK_EN
      second_cost  <= '0;
`endif
    end else begin
      disp_valid <= 1'b0;
      seq_err    <= 1'b0;
      case (state)
        IDLE: begin
          if (sum_valid) begin
            if (blk_index_i == 16'd0) begin
              best_cost  <= sum;
              best_idx   <= '0;
              pix_coords <= in_coords;
              exp_idx    <= 16'd1;
`ifdef UNIQUENESS_CHECK_EN
              second_cost <= '1;
`endif
              if (num_disp == 1) begin
                // Single-candidate pixel: the candidate is the result.
                disp         <= '0;
                disp_cost    <= sum;
                out_coords   <= in_coords;
                disp_invalid <= 1'b0;
                disp_valid   <= 1'b1;
                exp_idx      <= '0;
              end else begin
                state <= ACCUM;
              end
            end else begin
              seq_err <= 1'b1;
            end
          end
        end
        ACCUM: begin
          if (sum_valid) begin
            if (blk_index_i == exp_idx) begin
              best_cost <= nxt_best_cost;
              best_idx  <= nxt_best_idx;
              exp_idx   <= exp_idx + 16'd1;
`ifdef UNIQUENESS_CHECK_EN
              second_cost <= nxt_second;
`endif
              if (blk_index_i == LAST_IDX) begin
                disp         <= nxt_best_idx;
                disp_cost    <= nxt_best_cost;
                out_coords   <= pix_coords;
                disp_invalid <= ambiguous;
                disp_valid   <= 1'b1;
                exp_idx      <= '0;
                state        <= IDLE;
              end
            end else if (blk_index_i == 16'd0) begin
              // Early restart: abandon the partial pixel, begin a new one.
              seq_err    <= 1'b1;
              best_cost  <= sum;
              best_idx   <= '0;
              pix_coords <= in_coords;
              exp_idx    <= 16'd1;
`ifdef UNIQUENESS_CHECK_EN
              second_cost <= '1;
`endif
            end else begin
              seq_err <= 1'b1;
              exp_idx <= '0;
              state   <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_min_cost_select.sv
// Directed bench for min_cost_select with num_disp = 4.
module tb_min_cost_select;
  localparam int ND = 4;
  localparam int CB = 8;
  localparam int DB = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic [CB-1:0] sum;
  logic [15:0]   in_coords;
  logic [15:0]   blk_index_i;
  logic          sum_valid;
  logic [DB-1:0] disp;
  logic [CB-1:0] disp_cost;
  logic [15:0]   out_coords;
  logic          disp_invalid;
  logic          disp_valid;
  logic          seq_err;

  int n_cmp = 0;
  int n_bad = 0;
  int n_valid = 0;
  int n_err = 0;

  min_cost_select #(.num_disp(ND), .cost_bits(CB), .uniq_margin(2)) dut (
    .clk(clk), .reset(reset), .sum(sum), .in_coords(in_coords),
    .blk_index_i(blk_index_i), .sum_valid(sum_valid), .disp(disp),
    .disp_cost(disp_cost), .out_coords(out_coords),
    .disp_invalid(disp_invalid), .disp_valid(disp_valid), .seq_err(seq_err)
  );

  always #5 clk = ~clk;

  // Pulse counters, sampled away from the active edge.
  always @(negedge clk) begin
    if (disp_valid === 1'b1) n_valid++;
    if (seq_err === 1'b1) n_err++;
  end

  // Present one candidate for one clock; returns 1 time unit after the edge.
  task automatic cand(input int idx, input int cost, input logic [15:0] co);
    sum_valid = 1'b1;
    blk_index_i = 16'(idx);
    sum = CB'(cost);
    in_coords = co;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    sum_valid = 1'b0;
    blk_index_i = 16'hBEEF;
    sum = 8'hFF;
    in_coords = 16'hFFFF;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Full in-order pixel; later candidates carry junk coordinates.
  task automatic pix(input int c0, input int c1, input int c2, input int c3,
                     input logic [15:0] co);
    cand(0, c0, co);
    cand(1, c1, 16'hDEAD);
    cand(2, c2, 16'hDEAD);
    cand(3, c3, 16'hDEAD);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    idle(2);
    n_cmp++; if (disp_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid got=%0b exp=0", disp_valid); end
    n_cmp++; if (seq_err !== 1'b0) begin n_bad++; $display("FAIL rst_seq_err got=%0b exp=0", seq_err); end
    n_cmp++; if (disp !== 2'd0) begin n_bad++; $display("FAIL rst_disp got=%0d exp=0", disp); end
    n_cmp++; if (disp_cost !== 8'd0) begin n_bad++; $display("FAIL rst_cost got=%0d exp=0", disp_cost); end
    n_cmp++; if (out_coords !== 16'h0) begin n_bad++; $display("FAIL rst_coords got=%h exp=0000", out_coords); end
    n_cmp++; if (disp_invalid !== 1'b0) begin n_bad++; $display("FAIL rst_invalid got=%0b exp=0", disp_invalid); end
    reset = 1'b0;
    idle(1);
  endtask

  task automatic test_basic;
    pix(9, 5, 7, 6, 16'h0A14);
    n_cmp++; if (disp_valid !== 1'b1) begin n_bad++; $display("FAIL basic_valid got=%0b exp=1", disp_valid); end
    n_cmp++; if (disp !== 2'd1) begin n_bad++; $display("FAIL basic_disp got=%0d exp=1", disp); end
    n_cmp++; if (disp_cost !== 8'd5) begin n_bad++; $display("FAIL basic_cost got=%0d exp=5", disp_cost); end
    n_cmp++; if (out_coords !== 16'h0A14) begin n_bad++; $display("FAIL basic_coords got=%h exp=0a14", out_coords); end
    idle(1);
    n_cmp++; if (disp_valid !== 1'b0) begin n_bad++; $display("FAIL basic_strobe_len got=%0b exp=0", disp_valid); end
    n_cmp++; if (disp_cost !== 8'd5) begin n_bad++; $display("FAIL basic_hold got=%0d exp=5", disp_cost); end
  endtask

  task automatic test_ties;
    pix(3, 3, 8, 3, 16'h0102);
    n_cmp++; if (disp !== 2'd0) begin n_bad++; $display("FAIL tie_disp got=%0d exp=0", disp); end
    n_cmp++; if (disp_cost !== 8'd3) begin n_bad++; $display("FAIL tie_cost got=%0d exp=3", disp_cost); end
    idle(1);
    pix(9, 9, 9, 2, 16'h0304);
    n_cmp++; if (disp_valid !== 1'b1) begin n_bad++; $display("FAIL late_valid got=%0b exp=1", disp_valid); end
    n_cmp++; if (disp !== 2'd3) begin n_bad++; $display("FAIL late_disp got=%0d exp=3", disp); end
    n_cmp++; if (disp_cost !== 8'd2) begin n_bad++; $display("FAIL late_cost got=%0d exp=2", disp_cost); end
    idle(1);
  endtask

  task automatic test_back_to_back;
    int v0;
    v0 = n_valid;
    pix(4, 8, 1, 6, 16'h1111);
    n_cmp++; if (disp !== 2'd2 || disp_cost !== 8'd1 || out_coords !== 16'h1111)
      begin n_bad++; $display("FAIL b2b_a got=%0d/%0d/%h exp=2/1/1111", disp, disp_cost, out_coords); end
    pix(7, 7, 7, 0, 16'h2222);
    n_cmp++; if (disp_valid !== 1'b1 || disp !== 2'd3 || disp_cost !== 8'd0 || out_coords !== 16'h2222)
      begin n_bad++; $display("FAIL b2b_b got=%0b/%0d/%0d/%h exp=1/3/0/2222", disp_valid, disp, disp_cost, out_coords); end
    cand(0, 50, 16'h3333);
    cand(1, 20, 16'hDEAD);
    idle(3);
    n_cmp++; if (disp_valid !== 1'b0) begin n_bad++; $display("FAIL gap_no_valid got=%0b exp=0", disp_valid); end
    cand(2, 30, 16'hDEAD);
    cand(3, 21, 16'hDEAD);
    n_cmp++; if (disp_valid !== 1'b1 || disp !== 2'd1 || disp_cost !== 8'd20 || out_coords !== 16'h3333)
      begin n_bad++; $display("FAIL gap_c got=%0b/%0d/%0d/%h exp=1/1/20/3333", disp_valid, disp, disp_cost, out_coords); end
    idle(2);
    n_cmp++; if (n_valid - v0 !== 3) begin n_bad++; $display("FAIL b2b_strobes got=%0d exp=3", n_valid - v0); end
  endtask

  task automatic test_seq_err;
    int v0, e0;
    v0 = n_valid; e0 = n_err;
    cand(0, 1, 16'h0101);
    cand(1, 1, 16'h0101);
    cand(3, 1, 16'h0101);
    n_cmp++; if (seq_err !== 1'b1) begin n_bad++; $display("FAIL skip_err got=%0b exp=1", seq_err); end
    n_cmp++; if (disp_valid !== 1'b0) begin n_bad++; $display("FAIL skip_valid got=%0b exp=0", disp_valid); end
    idle(1);
    n_cmp++; if (seq_err !== 1'b0) begin n_bad++; $display("FAIL skip_err_len got=%0b exp=0", seq_err); end
    // Back in IDLE: a fresh pixel completes without further errors.
    pix(6, 5, 4, 3, 16'h0505);
    n_cmp++; if (disp_valid !== 1'b1 || disp !== 2'd3 || seq_err !== 1'b0)
      begin n_bad++; $display("FAIL after_skip got=%0b/%0d/%0b exp=1/3/0", disp_valid, disp, seq_err); end
    idle(1);
    cand(2, 1, 16'h0606);
    n_cmp++; if (seq_err !== 1'b1) begin n_bad++; $display("FAIL idle_err got=%0b exp=1", seq_err); end
    idle(1);
    n_cmp++; if (n_err - e0 !== 2 || n_valid - v0 !== 1)
      begin n_bad++; $display("FAIL seq_counts got=%0d/%0d exp=2/1", n_err - e0, n_valid - v0); end
    v0 = n_valid; e0 = n_err;
    cand(0, 1, 16'h1010);
    cand(1, 1, 16'h1010);
    cand(0, 8, 16'h2020);
    n_cmp++; if (seq_err !== 1'b1) begin n_bad++; $display("FAIL restart_err got=%0b exp=1", seq_err); end
    cand(1, 7, 16'hDEAD);
    cand(2, 6, 16'hDEAD);
    cand(3, 9, 16'hDEAD);
    n_cmp++; if (disp_valid !== 1'b1 || disp !== 2'd2 || disp_cost !== 8'd6 || out_coords !== 16'h2020)
      begin n_bad++; $display("FAIL restart_res got=%0b/%0d/%0d/%h exp=1/2/6/2020", disp_valid, disp, disp_cost, out_coords); end
    idle(1);
    n_cmp++; if (n_err - e0 !== 1 || n_valid - v0 !== 1)
      begin n_bad++; $display("FAIL restart_counts got=%0d/%0d exp=1/1", n_err - e0, n_valid - v0); end
  endtask

  task automatic test_reset_mid;
    int e0;
    cand(0, 2, 16'h4444);
    cand(1, 1, 16'h4444);
    reset = 1'b1;
    cand(2, 0, 16'h4444);  // reset wins over this candidate
    n_cmp++; if (disp_valid !== 1'b0 || seq_err !== 1'b0 || disp !== 2'd0 || disp_cost !== 8'd0 || out_coords !== 16'h0)
      begin n_bad++; $display("FAIL midrst got=%0b/%0b/%0d/%0d/%h exp=0/0/0/0/0000", disp_valid, seq_err, disp, disp_cost, out_coords); end
    reset = 1'b0;
    idle(1);
    e0 = n_err;
    pix(2, 1, 3, 4, 16'h4545);
    n_cmp++; if (disp_valid !== 1'b1 || disp !== 2'd1 || disp_cost !== 8'd1 || out_coords !== 16'h4545)
      begin n_bad++; $display("FAIL post_rst got=%0b/%0d/%0d/%h exp=1/1/1/4545", disp_valid, disp, disp_cost, out_coords); end
    idle(1);
    n_cmp++; if (n_err !== e0) begin n_bad++; $display("FAIL post_rst_err got=%0d exp=0", n_err - e0); end
  endtask

  task automatic test_uniqueness;
    pix(10, 4, 5, 20, 16'h0707);
    n_cmp++; if (disp !== 2'd1) begin n_bad++; $display("FAIL uniq_disp got=%0d exp=1", disp); end
`ifdef UNIQUENESS_CHECK_EN
    n_cmp++; if (disp_invalid !== 1'b1) begin n_bad++; $display("FAIL uniq_gap1 got=%0b exp=1", disp_invalid); end
    idle(1);
    pix(10, 4, 6, 20, 16'h0707);
    n_cmp++; if (disp_invalid !== 1'b0) begin n_bad++; $display("FAIL uniq_gap2 got=%0b exp=0", disp_invalid); end
    idle(1);
    pix(4, 10, 10, 10, 16'h0707);
    n_cmp++; if (disp_invalid !== 1'b0 || disp !== 2'd0) begin n_bad++; $display("FAIL uniq_gap6 got=%0b/%0d exp=0/0", disp_invalid, disp); end
`else
    n_cmp++; if (disp_invalid !== 1'b0) begin n_bad++; $display("FAIL uniq_off got=%0b exp=0", disp_invalid); end
`endif
    idle(1);
  endtask

  initial begin
    reset = 1'b1;
    sum_valid = 1'b0;
    sum = '0;
    in_coords = '0;
    blk_index_i = '0;
    #2;
    test_reset();
    test_basic();
    test_ties();
    test_back_to_back();
    test_seq_err();
    test_reset_mid();
    test_uniqueness();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/min_cost_select.md
# min_cost_select

Winner-take-all disparity selector sitting directly downstream of the Hamming-distance stage. Consumes the per-candidate cost stream (cost, coordinates, block index, valid), tracks the minimum-cost candidate across the disparity range of one pixel, and emits one registered result per pixel: winning block index, its cost and the pixel coordinates. Also detects candidate-sequence errors and, optionally, flags ambiguous matches.

## Interface
- `num_disp`, 64: candidates per pixel; block indices 0..num_disp-1; legal range 1..65535.
- `cost_bits`, 8: width of the cost input.
- `disp_bits`, `$clog2(num_disp)` (minimum 1): width of the disparity output.
- `uniq_margin`, 2: minimum required cost gap between best and second-best (used only with `UNIQUENESS_CHECK_EN`).

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high reset.
- `sum`  in  cost_bits  candidate cost.
- `in_coords`  in  16  pixel coordinates {y[15:8], x[7:0]}.
- `blk_index_i`  in  16  candidate index.
- `sum_valid`  in  1  candidate qualifier; no backpressure.
- `disp`  out  disp_bits  winning index.
- `disp_cost`  out  cost_bits  winning cost.
- `out_coords`  out  16  coordinates of the pixel.
- `disp_invalid`  out  1  match is ambiguous.
- `disp_valid`  out  1  one-cycle result strobe.
- `seq_err`  out  1  one-cycle strobe: candidate-sequence violation.

## Operation
- States: IDLE, ACCUM.
- Registers: `exp_idx`, `best_cost`, `best_idx`, `pix_coords`.
- IDLE + valid + index 0:
  - Load `best_cost` = sum, `best_idx` = 0, `pix_coords` = in_coords, `exp_idx` = 1.
  - Go to ACCUM; if num_disp == 1, complete immediately instead.
- IDLE + valid + index ≠ 0: discard the candidate, pulse `seq_err`, stay in IDLE.
- ACCUM + valid + index == `exp_idx`:
  - If sum < `best_cost` (strict), replace best. Ties keep the lower index.
  - Increment `exp_idx`.
  - If index == num_disp-1, complete the pixel and go to IDLE.
- ACCUM + valid + index == 0 (early restart): drop the partial pixel, pulse `seq_err`, start a new pixel from this candidate.
- ACCUM + valid + any other index: drop the partial pixel, pulse `seq_err`, go to IDLE.
- Gaps in `sum_valid` are legal in any state; state is held.
- Coordinates are latched from the index-0 candidate. Coordinates on later candidates of the same pixel are ignored.
- Completion: the result registers load the final comparison outcome. This includes the last candidate when it wins; the comparison is done combinationally, not taken from the stale register.

## Timing
- Last candidate at cycle N ⇒ `disp_valid` high at N+1 for exactly one cycle. The outputs hold their values until the next completion.
- `seq_err` asserts at N+1 relative to the offending candidate.
- Back-to-back pixels at full rate: one candidate per cycle, with index 0 directly following index num_disp-1, and no bubbles.
- Reset values:
  - State IDLE, `exp_idx` = 0.
  - `disp`, `disp_cost`, `out_coords` = 0.
  - `disp_invalid`, `disp_valid`, `seq_err` = 0.
- Reset mid-pixel abandons the pixel with no output and no `seq_err`.
- Reset wins over `sum_valid` in the same cycle.
- Throughput is one candidate per cycle; there is no internal buffering beyond the result register.

## Configuration
- `UNIQUENESS_CHECK_EN` defined:
  - Also track `second_cost`, the minimum over all candidates other than the winner.
  - On a new best, the old best moves to second. On a non-winning candidate, update second if it is lower.
  - At completion, `disp_invalid` = (`second_cost` − `best_cost` < `uniq_margin`), compared unsigned with no underflow, since second ≥ best.
  - With num_disp == 1, `disp_invalid` = 0.
- `UNIQUENESS_CHECK_EN` undefined: no second-best logic is built; `disp_invalid` is tied to 0.

## Test plan
- num_disp=4; costs {9,5,7,6} on indices 0..3 with coords 0x0A14 → one cycle after index 3: `disp_valid`=1, `disp`=1, `disp_cost`=5, `out_coords`=0x0A14.
- Ties and late winner:
  - costs {3,3,8,3} → `disp`=0, `disp_cost`=3.
  - costs {9,9,9,2} → `disp`=3, `disp_cost`=2, strobe at last+1.
- Two pixels back-to-back with no bubbles, plus a third pixel with a 3-cycle valid gap after index 1 → three correct results, each a single-cycle `disp_valid`.
- Sequence errors:
  - Indices 0,1,3 → `seq_err` pulse, no `disp_valid`, state returns to IDLE.
  - Index 2 while in IDLE → `seq_err` pulse.
  - Indices 0,1,0,1,2,3 → one `seq_err` pulse, then a valid result for the restarted pixel.
- Reset asserted after index 1 of a 4-candidate pixel → all outputs 0; the next full pixel is processed normally, with no `seq_err`.
- `UNIQUENESS_CHECK_EN`, uniq_margin=2:
  - costs {10,4,5,20} → `disp`=1, `disp_invalid`=1.
  - costs {10,4,6,20} → `disp_invalid`=0.
  - costs {4,10,10,10} → `disp_invalid`=0.
